// File: rtl/e203_exu_longp_wbuf.sv
// e203_exu_longp_wbuf: two-entry long-pipe write-back buffer between LSU/divider results
// and the final write-back / exception channels, retiring the matching OITF head on accept.
`ifndef E203_XLEN
`define E203_XLEN 32
`endif
`ifndef E203_FLEN
`define E203_FLEN 64
`endif
`ifndef E203_ITAG_WIDTH
`define E203_ITAG_WIDTH 1
`endif
`ifndef E203_RFIDX_WIDTH
`define E203_RFIDX_WIDTH 5
`endif

module e203_exu_longp_wbuf #(
    parameter int ITAG_W = `E203_ITAG_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         lsu_wbck_i_valid,
    output logic                         lsu_wbck_i_ready,
    input  logic [`E203_XLEN-1:0]        lsu_wbck_i_wdat,
    input  logic [ITAG_W-1:0]            lsu_wbck_i_itag,
    input  logic                         lsu_wbck_i_err,
    input  logic                         div_wbck_i_valid,
    output logic                         div_wbck_i_ready,
    input  logic [`E203_XLEN-1:0]        div_wbck_i_wdat,
    input  logic [ITAG_W-1:0]            div_wbck_i_itag,
    input  logic                         div_wbck_i_err,
    input  logic                         oitf_empty,
    input  logic [ITAG_W-1:0]            oitf_ret_ptr,
    input  logic [`E203_RFIDX_WIDTH-1:0] oitf_ret_rdidx,
    input  logic                         oitf_ret_rdwen,
    input  logic                         oitf_ret_rdfpu,
    output logic                         oitf_ret_ena,
    output logic                         longp_wbck_o_valid,
    input  logic                         longp_wbck_o_ready,
    output logic [`E203_FLEN-1:0]        longp_wbck_o_wdat,
    output logic [4:0]                   longp_wbck_o_flags,
    output logic [`E203_RFIDX_WIDTH-1:0] longp_wbck_o_rdidx,
    output logic                         longp_wbck_o_rdfpu,
    output logic                         longp_excp_o_valid,
    input  logic                         longp_excp_o_ready,
    output logic                         longp_excp_o_src
);
    localparam logic [1:0] DEPTH = 2'd2;

    typedef struct packed {
        logic [`E203_XLEN-1:0]        wdat;
        logic                         err;
        logic                         src;
        logic [`E203_RFIDX_WIDTH-1:0] rdidx;
        logic                         rdwen;
        logic                         rdfpu;
    } ent_t;

    ent_t       ent_q [2];
    ent_t       ent_d [2];
    ent_t       head;
    logic [1:0] cnt_q, cnt_d;
    logic       wptr_q, wptr_d, rptr_q, rptr_d;
    logic       lsu_hit, div_hit, full, push, pop, nonempty, wbck_vld, excp_vld;

    // rst_n gates the accept path so no OITF entry retires while held in reset
    always_comb begin
        lsu_hit  = lsu_wbck_i_valid & ~oitf_empty & (lsu_wbck_i_itag == oitf_ret_ptr);
        div_hit  = div_wbck_i_valid & ~oitf_empty & (div_wbck_i_itag == oitf_ret_ptr);
        full     = (cnt_q == DEPTH);
        push     = (lsu_hit | div_hit) & ~full & rst_n;
        head     = ent_q[rptr_q];
        nonempty = (cnt_q != 2'd0);
        excp_vld = nonempty & head.err;
        wbck_vld = nonempty & ~head.err & head.rdwen;
        pop      = excp_vld ? longp_excp_o_ready : wbck_vld ? longp_wbck_o_ready : nonempty;
        ent_d    = ent_q;
        if (push)
            ent_d[wptr_q] = {lsu_hit ? lsu_wbck_i_wdat : div_wbck_i_wdat,
                             lsu_hit ? lsu_wbck_i_err : div_wbck_i_err,
                             lsu_hit, oitf_ret_rdidx, oitf_ret_rdwen, oitf_ret_rdfpu};
        wptr_d   = wptr_q ^ push;
        rptr_d   = rptr_q ^ pop;
        cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    assign lsu_wbck_i_ready   = lsu_hit & ~full & rst_n;
    assign div_wbck_i_ready   = div_hit & ~lsu_hit & ~full & rst_n;
    assign oitf_ret_ena       = push;
    assign longp_wbck_o_valid = wbck_vld;
    assign longp_wbck_o_wdat  = wbck_vld ? `E203_FLEN'(head.wdat) : '0;
    assign longp_wbck_o_flags = 5'b0;
    assign longp_wbck_o_rdidx = wbck_vld ? head.rdidx : '0;
    assign longp_wbck_o_rdfpu = wbck_vld & head.rdfpu;
    assign longp_excp_o_valid = excp_vld;
    assign longp_excp_o_src   = excp_vld & head.src;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 2'd0;
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end
endmodule
